rx_frame_ctrl: RTL and testbench

//  Parametrised UART receive controller. It detects the start bit, times and

---
 rtl/rx_frame_pkg.sv | 19 +
 rtl/rx_bit_timer.sv | 41 ++++
 rtl/rx_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the UART receive controller (rx_frame_ctrl).
// The optional parity stage is built only when RX_PARITY_EN is defined.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        SAVE   = 3'd5
    } rx_state_t;

    // Offset from the start edge to the centre of the start bit.
    function automatic int half_period(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Down-counting bit timer: loads a half or a full bit period and flags the
// cycle in which the count has run out, which is the sample point.
module rx_bit_timer
    import rx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic load_i,
    input  logic half_i,
    input  logic en_i,
    output logic sample_tick_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(half_period(CLKS_PER_BIT) - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = half_i ? HALF_LOAD : FULL_LOAD;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sample_tick_o = en_i && (count_q == '0);

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive controller: start detect, bit sampling, one-entry output
// buffer with framing/parity/overrun flags. Parity stage under RX_PARITY_EN.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 parity_odd,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 prev_serial_q;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 framing_error_q, framing_error_d;
    logic                 overrun_error_q, overrun_error_d;
`ifdef RX_PARITY_EN
    logic                 par_err_q, par_err_d;
    logic                 parity_error_q, parity_error_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    logic timer_load, timer_half, timer_en, sample_tick, start_edge;

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_i       (timer_load),
        .half_i       (timer_half),
        .en_i         (timer_en),
        .sample_tick_o(sample_tick)
    );

    assign start_edge = (state_q == IDLE) && !serial_in && prev_serial_q;
    assign timer_en   = (state_q != IDLE) && (state_q != SAVE);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = frame_err_q;
        timer_load  = 1'b0;
        timer_half  = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d     = START;
                    timer_load  = 1'b1;
                    timer_half  = 1'b1;
                    bit_cnt_d   = '0;
                    frame_err_d = 1'b0;
                end
            end
            START: begin
                // A line already back high at mid start bit was a glitch.
                if (sample_tick) begin
                    timer_load = 1'b1;
                    state_d    = serial_in ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_tick) begin
                    timer_load = 1'b1;
                    shift_d    = {serial_in, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
`ifdef RX_PARITY_EN
                if (sample_tick) begin
                    timer_load = 1'b1;
                    par_err_d  = ((^shift_q) ^ serial_in) != parity_odd;
                    state_d    = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (sample_tick) begin
                    timer_load = 1'b1;
                    if (!serial_in) begin
                        frame_err_d = 1'b1;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = SAVE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            SAVE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake: data_ready stays high until a cycle with data_read=1, which
    // retires the buffer (and its flags) on the following edge.
    always_comb begin
        rx_data_d       = rx_data_q;
        data_ready_d    = data_ready_q;
        framing_error_d = framing_error_q;
        overrun_error_d = overrun_error_q;
`ifdef RX_PARITY_EN
        parity_error_d  = parity_error_q;
`endif
        if (data_read && data_ready_q) begin
            data_ready_d    = 1'b0;
            overrun_error_d = 1'b0;
`ifdef RX_PARITY_EN
            parity_error_d  = 1'b0;
`endif
        end
        if (state_q == SAVE) begin
            if (frame_err_q) begin
                framing_error_d = 1'b1;
            end else begin
                rx_data_d       = shift_q;
                data_ready_d    = 1'b1;
                framing_error_d = 1'b0;
`ifdef RX_PARITY_EN
                parity_error_d  = par_err_q;
`endif
                if (data_ready_q && !data_read) begin
                    overrun_error_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            prev_serial_q   <= 1'b1;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            frame_err_q     <= 1'b0;
            rx_data_q       <= '0;
            data_ready_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_error_q <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q       <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            prev_serial_q   <= serial_in;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            frame_err_q     <= frame_err_d;
            rx_data_q       <= rx_data_d;
            data_ready_q    <= data_ready_d;
            framing_error_q <= framing_error_d;
            overrun_error_q <= overrun_error_d;
`ifdef RX_PARITY_EN
            par_err_q       <= par_err_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = framing_error_q;
    assign overrun_error = overrun_error_q;
    assign busy          = (state_q != IDLE);
`ifdef RX_PARITY_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl (default build or RX_PARITY_EN): directed frames,
// scoreboard of expected buffer state popped when busy falls.
module tb_rx_frame_ctrl;

    logic       clk;
    logic       n_rst;
    logic       serial_in, serial2;
    logic       parity_odd;
    logic       data_read, read2;
    logic [7:0] rx_data, rx_data2;
    logic       data_ready, data_ready2;
    logic       framing_error, framing_error2;
    logic       parity_error, parity_error2;
    logic       overrun_error, overrun_error2;
    logic       busy, busy2;

    rx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .parity_odd(parity_odd),
        .data_read(data_read), .rx_data(rx_data), .data_ready(data_ready),
        .framing_error(framing_error), .parity_error(parity_error),
        .overrun_error(overrun_error), .busy(busy)
    );

    rx_frame_ctrl #(.DATA_BITS(8), .STOP_BITS(2), .CLKS_PER_BIT(16)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial2), .parity_odd(parity_odd),
        .data_read(read2), .rx_data(rx_data2), .data_ready(data_ready2),
        .framing_error(framing_error2), .parity_error(parity_error2),
        .overrun_error(overrun_error2), .busy(busy2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    // scoreboard entry: {latency[7:0], rx_data[7:0], ready, fe, pe, oe}
    logic [19:0] exp_q[$];
    int          t_start = 0;
    bit          mon_off = 1'b1;
    logic        busy_prev = 1'b0;

    logic [7:0] m_data;
    bit         m_ready, m_fe, m_pe, m_oe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit good_par(input logic [7:0] d);
        return (^d) ^ parity_odd;
    endfunction

    task automatic model_reset();
        m_data = '0; m_ready = 0; m_fe = 0; m_pe = 0; m_oe = 0;
    endtask

    // driver tasks
    task automatic drive_bit(input bit sel, input bit b, input int n);
        if (sel) serial2 = b; else serial_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_bit,
                              input bit stop_last, input bit rd_at_save);
        bit ovr;
        bit pe_new;
        int lat;
        if (!sel) begin
`ifdef RX_PARITY_EN
            pe_new = ((^d) ^ par_bit) != parity_odd;
            lat    = 170;
`else
            pe_new = 1'b0;
            lat    = 154;
`endif
            ovr = m_ready && !rd_at_save;
            if (rd_at_save && m_ready) begin
                m_ready = 0; m_pe = 0; m_oe = 0;
            end
            if (!stop_last) begin
                m_fe = 1;
            end else begin
                m_data = d; m_ready = 1; m_fe = 0; m_pe = pe_new;
                if (ovr) m_oe = 1;
            end
            exp_q.push_back({8'(lat), m_data, m_ready, m_fe, m_pe, m_oe});
            t_start = cyc;
        end
        drive_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 16);
`ifdef RX_PARITY_EN
        drive_bit(sel, par_bit, 16);
`endif
        if (sel) drive_bit(sel, 1'b1, 16);
        // last stop bit: its sample is 8 cycles in, SAVE follows one cycle later
        drive_bit(sel, stop_last, 9);
        if (sel) read2 = rd_at_save; else data_read = rd_at_save;
        @(negedge clk);
        data_read = 1'b0;
        read2     = 1'b0;
        drive_bit(sel, 1'b1, 6);
    endtask

    task automatic read_buf();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        if (m_ready) begin
            m_ready = 0; m_pe = 0; m_oe = 0;
        end
        check("after_read", 32'({rx_data, data_ready, framing_error, parity_error, overrun_error}),
              32'({m_data, m_ready, m_fe, m_pe, m_oe}));
    endtask

    task automatic abort_frame(input bit sel, input logic [7:0] d);
        mon_off = 1'b1;
        drive_bit(sel, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(sel, d[i], 16);
        drive_bit(sel, d[3], 8);
        n_rst = 1'b0;
        #1;
        if (sel)
            check("abort_reset_d2", 32'({rx_data2, data_ready2, framing_error2, parity_error2,
                  overrun_error2, busy2}), 32'(0));
        else
            check("abort_reset", 32'({rx_data, data_ready, framing_error, parity_error,
                  overrun_error, busy}), 32'(0));
        serial_in = 1'b1;
        serial2   = 1'b1;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        mon_off = 1'b0;
    endtask

    // scoreboard monitor: compare when a receive ends
    always @(negedge clk) begin
        logic [19:0] e;
        if (!mon_off && busy_prev && !busy) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("latency", 32'(cyc - t_start), 32'(e[19:12]));
            check("outputs", 32'({rx_data, data_ready, framing_error, parity_error, overrun_error}),
                  32'(e[11:0]));
        end
        busy_prev <= busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] d;
        bit rd;
        n_rst = 1'b0; serial_in = 1'b1; serial2 = 1'b1;
        parity_odd = 1'b0; data_read = 1'b0; read2 = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({rx_data, data_ready, framing_error, parity_error,
              overrun_error, busy}), 32'(0));
        check("reset_outputs_d2", 32'({rx_data2, data_ready2, framing_error2, parity_error2,
              overrun_error2, busy2}), 32'(0));
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_off = 1'b0;

        // good frame
        send_frame(0, 8'hA5, good_par(8'hA5), 1'b1, 1'b0);

        // false start: 4 low cycles, busy for 8 cycles
        exp_q.push_back({8'd9, m_data, m_ready, m_fe, m_pe, m_oe});
        t_start   = cyc;
        serial_in = 1'b0;
        cnt       = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) serial_in = 1'b1;
            cnt += int'(busy);
        end
        check("false_start_busy", 32'(cnt), 32'(8));
        repeat (4) @(negedge clk);

        // framing error then a good frame
        read_buf();
        send_frame(0, 8'h3C, good_par(8'h3C), 1'b0, 1'b0);
        send_frame(0, 8'h3C, good_par(8'h3C), 1'b1, 1'b0);
        read_buf();

        // overrun, then read clears, then read coincident with SAVE
        send_frame(0, 8'h11, good_par(8'h11), 1'b1, 1'b0);
        send_frame(0, 8'h22, good_par(8'h22), 1'b1, 1'b0);
        read_buf();
        send_frame(0, 8'h33, good_par(8'h33), 1'b1, 1'b0);
        send_frame(0, 8'h44, good_par(8'h44), 1'b1, 1'b1);
        read_buf();

        // parity cases (parity_error stays 0 when the stage is not built)
        parity_odd = 1'b0;
        send_frame(0, 8'h07, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h07, 1'b1, 1'b1, 1'b1);
        parity_odd = 1'b1;
        send_frame(0, 8'h07, 1'b0, 1'b1, 1'b1);
        send_frame(0, 8'h0F, 1'b0, 1'b1, 1'b1);
        parity_odd = 1'b0;

        // random frames
        for (int i = 0; i < 4; i++) begin
            d  = 8'($urandom_range(0, 255));
            rd = 1'($urandom_range(0, 1));
            send_frame(0, d, 1'($urandom_range(0, 1)), 1'b1, rd);
        end

        // reset mid-frame, then recovery
        abort_frame(0, 8'h96);
        send_frame(0, 8'h5A, good_par(8'h5A), 1'b1, 1'b0);

        // two stop bits: abort, then bad second stop, then good
        abort_frame(1, 8'hC3);
        send_frame(1, 8'h5A, good_par(8'h5A), 1'b0, 1'b0);
        check("d2_stop2_low", 32'({rx_data2, data_ready2, framing_error2, parity_error2,
              overrun_error2}), 32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
        send_frame(1, 8'h5A, good_par(8'h5A), 1'b1, 1'b0);
        check("d2_good", 32'({rx_data2, data_ready2, framing_error2, parity_error2,
              overrun_error2}), 32'({8'h5A, 1'b1, 1'b0, 1'b0, 1'b0}));

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
